// File: rtl/lfsr_engine.sv
// Parametrised Galois LFSR with nibble-wide seed/tap loading and a prescaled free-run step.
// Define LFSR_PERIOD_EN to compile in the cycle-length measurement unit.
module lfsr_engine #(
  parameter int          WIDTH    = 16,
  parameter logic [31:0] SEED     = 32'h0000_0001,
  parameter logic [31:0] TAPS     = 32'h0000_B400,
  parameter int          CLOCK_HZ = 1000,
  parameter int          STEP_HZ  = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  input  logic [3:0]       i_data,
  output logic [7:0]       o_out,
  output logic [WIDTH-1:0] o_period,
  output logic             o_period_valid
);

  localparam int DIV = CLOCK_HZ / STEP_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] TAPS_W = TAPS[WIDTH-1:0];

  typedef enum logic [1:0] {
    CMD_NOP        = 2'b00,
    CMD_SHIFT_SEED = 2'b01,
    CMD_SHIFT_TAPS = 2'b10,
    CMD_STEP       = 2'b11
  } cmd_e;

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_taps;
  logic [PW-1:0]    r_presc;
  logic             w_tick;
  logic             w_loadSeed;
  logic             w_loadTaps;
  logic             w_doStep;
  logic [WIDTH-1:0] w_stepState;
  logic [WIDTH-1:0] w_shiftSeed;
  logic [WIDTH-1:0] w_shiftTaps;

  assign w_tick     = i_run && (r_presc == PW'(DIV - 1));
  assign w_loadSeed = i_cmd_valid && (i_cmd == CMD_SHIFT_SEED);
  assign w_loadTaps = i_cmd_valid && (i_cmd == CMD_SHIFT_TAPS);
  // Any valid command swallows a coincident free-run tick.
  assign w_doStep   = i_cmd_valid ? (i_cmd == CMD_STEP) : w_tick;

  assign w_stepState = (r_state == '0) ? WIDTH'(1)
                     : ((r_state >> 1) ^ (r_state[0] ? r_taps : '0));

  generate
    if (WIDTH == 4) begin : g_narrow
      assign w_shiftSeed = i_data;
      assign w_shiftTaps = i_data;
    end else begin : g_wide
      assign w_shiftSeed = {r_state[WIDTH-5:0], i_data};
      assign w_shiftTaps = {r_taps[WIDTH-5:0], i_data};
    end
    if (WIDTH >= 8) begin : g_outWide
      assign o_out = r_state[7:0];
    end else begin : g_outNarrow
      assign o_out = {{(8 - WIDTH){1'b0}}, r_state};
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
    end else if (!i_run || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SEED_W;
      r_taps  <= TAPS_W;
    end else if (w_loadSeed) begin
      r_state <= w_shiftSeed;
    end else if (w_loadTaps) begin
      r_taps <= w_shiftTaps;
    end else if (w_doStep) begin
      r_state <= w_stepState;
    end
  end

`ifdef LFSR_PERIOD_EN
  logic [WIDTH-1:0] r_ref;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period;
  logic             r_periodValid;
  logic [WIDTH-1:0] w_countInc;

  assign w_countInc = (&r_count) ? r_count : r_count + 1'b1;

  // The reference is re-armed by every load; a return to it closes one measurement.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ref         <= SEED_W;
      r_count       <= '0;
      r_period      <= '0;
      r_periodValid <= 1'b0;
    end else if (w_loadSeed) begin
      r_ref         <= w_shiftSeed;
      r_count       <= '0;
      r_periodValid <= 1'b0;
    end else if (w_loadTaps) begin
      r_ref         <= r_state;
      r_count       <= '0;
      r_periodValid <= 1'b0;
    end else if (w_doStep) begin
      if (w_stepState == r_ref) begin
        r_period      <= w_countInc;
        r_periodValid <= 1'b1;
        r_count       <= '0;
      end else begin
        r_count <= w_countInc;
      end
    end
  end

  assign o_period       = r_period;
  assign o_period_valid = r_periodValid;
`else
  assign o_period       = '0;
  assign o_period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_engine.sv
// Self-checking bench for lfsr_engine: a 16-bit prescaled instance and a 4-bit full-rate instance
// compared against a spec-level model, plus fixed vectors for the documented corner cases.
module tb_lfsr_engine;

`ifdef LFSR_PERIOD_EN
  localparam bit PERIOD_EN = 1'b1;
`else
  localparam bit PERIOD_EN = 1'b0;
`endif

  typedef struct {
    bit         run;
    bit         cv;
    logic [1:0] cmd;
    logic [3:0] data;
  } StimT;

  typedef struct {
    StimT       s;
    logic [7:0] expOut;
  } VecT;

  typedef struct {
    longint state;
    longint taps;
    longint refState;
    longint count;
    longint period;
    bit     pv;
    int     runCycles;
    int     width;
    int     div;
    longint seed;
    longint tapsInit;
  } ModelT;

  logic        clk = 1'b0;
  logic        rstN;
  logic        runA, cvA, runB, cvB;
  logic [1:0]  cmdA, cmdB;
  logic [3:0]  dataA, dataB;
  logic [7:0]  outA, outB;
  logic [15:0] periodA;
  logic [3:0]  periodB;
  logic        pvA, pvB;

  int    checks = 0;
  int    failures = 0;
  ModelT mA, mB;

  lfsr_engine #(.WIDTH(16), .SEED(32'h1), .TAPS(32'hB400), .CLOCK_HZ(8), .STEP_HZ(2)) dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_run(runA), .i_cmd_valid(cvA), .i_cmd(cmdA),
    .i_data(dataA), .o_out(outA), .o_period(periodA), .o_period_valid(pvA));

  lfsr_engine #(.WIDTH(4), .SEED(32'h1), .TAPS(32'hC), .CLOCK_HZ(1000), .STEP_HZ(1000)) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_run(runB), .i_cmd_valid(cvB), .i_cmd(cmdB),
    .i_data(dataB), .o_out(outB), .o_period(periodB), .o_period_valid(pvB));

  initial forever #5 clk = ~clk;

  function automatic StimT mk(bit run, bit cv, logic [1:0] cmd, logic [3:0] data);
    StimT s;
    s.run = run; s.cv = cv; s.cmd = cmd; s.data = data;
    return s;
  endfunction

  function automatic ModelT modelReset(ModelT m);
    m.state = m.seed; m.taps = m.tapsInit; m.refState = m.seed;
    m.count = 0; m.period = 0; m.pv = 1'b0; m.runCycles = 0;
    return m;
  endfunction

  // One clock of the engine from its documented rules; ticks come every DIV-th cycle of continuous run.
  function automatic ModelT modelCycle(ModelT m, StimT s);
    longint mask = (64'd1 << m.width) - 1;
    bit tick, doStep;
    if (s.run) m.runCycles++; else m.runCycles = 0;
    tick = s.run && (m.runCycles % m.div == 0);
    doStep = s.cv ? (s.cmd == 2'b11) : tick;
    if (s.cv && s.cmd == 2'b01) begin
      m.state = ((m.state << 4) | longint'(s.data)) & mask;
      m.refState = m.state; m.count = 0; m.pv = 1'b0;
    end else if (s.cv && s.cmd == 2'b10) begin
      m.taps = ((m.taps << 4) | longint'(s.data)) & mask;
      m.refState = m.state; m.count = 0; m.pv = 1'b0;
    end else if (doStep) begin
      if (m.state == 0) m.state = 1;
      else m.state = (m.state >> 1) ^ ((m.state % 2 == 1) ? m.taps : 0);
      if (m.state == m.refState) begin
        m.period = (m.count + 1 > mask) ? mask : m.count + 1;
        m.pv = 1'b1; m.count = 0;
      end else begin
        m.count = (m.count + 1 > mask) ? mask : m.count + 1;
      end
    end
    return m;
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkDut(string tag, ModelT m, logic [7:0] out, logic [31:0] period, logic pv);
    checkOutput({tag, ".out"}, 64'(out), 64'(m.state & 'hFF));
    checkOutput({tag, ".period"}, 64'(period), PERIOD_EN ? 64'(m.period) : 64'd0);
    checkOutput({tag, ".periodValid"}, 64'(pv), PERIOD_EN ? 64'(m.pv) : 64'd0);
  endtask

  task automatic applyStimulus(StimT a, StimT b);
    runA = a.run; cvA = a.cv; cmdA = a.cmd; dataA = a.data;
    runB = b.run; cvB = b.cv; cmdB = b.cmd; dataB = b.data;
    @(posedge clk);
    #1;
    mA = modelCycle(mA, a);
    mB = modelCycle(mB, b);
    checkDut("A", mA, outA, 32'(periodA), pvA);
    checkDut("B", mB, outB, 32'(periodB), pvB);
  endtask

  initial begin
    VecT  vecA[$];
    StimT idle;
    StimT ra, rb;
    logic [7:0] seqB[15];
    logic [7:0] expPre[16];

    idle = mk(0, 0, 2'b00, 4'h0);
    mA.width = 16; mA.div = 4; mA.seed = 1; mA.tapsInit = 'hB400;
    mB.width = 4;  mB.div = 1; mB.seed = 1; mB.tapsInit = 'hC;

    vecA.push_back('{mk(0, 1, 2'b11, 4'h0), 8'h00});
    vecA.push_back('{mk(0, 1, 2'b11, 4'h0), 8'h00});
    vecA.push_back('{mk(0, 1, 2'b01, 4'h1), 8'h01});
    vecA.push_back('{mk(0, 1, 2'b01, 4'h2), 8'h12});
    vecA.push_back('{mk(0, 1, 2'b01, 4'h3), 8'h23});
    vecA.push_back('{mk(0, 1, 2'b01, 4'h4), 8'h34});
    vecA.push_back('{mk(0, 1, 2'b11, 4'h0), 8'h1A});
    vecA.push_back('{mk(0, 1, 2'b11, 4'h0), 8'h8D});
    vecA.push_back('{mk(0, 1, 2'b11, 4'h0), 8'h46});
    vecA.push_back('{mk(0, 1, 2'b01, 4'h0), 8'h60});
    vecA.push_back('{mk(0, 1, 2'b01, 4'h0), 8'h00});
    vecA.push_back('{mk(0, 1, 2'b01, 4'h0), 8'h00});
    vecA.push_back('{mk(0, 1, 2'b01, 4'h0), 8'h00});
    vecA.push_back('{mk(0, 1, 2'b11, 4'h0), 8'h01});
    vecA.push_back('{mk(0, 1, 2'b11, 4'h0), 8'h00});
    vecA.push_back('{mk(0, 0, 2'b00, 4'h0), 8'h00});

    seqB = '{8'hC, 8'h6, 8'h3, 8'hD, 8'hA, 8'h5, 8'hE, 8'h7,
             8'hF, 8'hB, 8'h9, 8'h8, 8'h4, 8'h2, 8'h1};
    expPre = '{8'h12, 8'h12, 8'h12, 8'h09, 8'h09, 8'h09, 8'h09, 8'h04,
               8'h04, 8'h04, 8'h04, 8'h02, 8'h02, 8'h02, 8'h02, 8'h01};

    rstN = 1'b0;
    runA = 0; cvA = 0; cmdA = 0; dataA = 0;
    runB = 0; cvB = 0; cmdB = 0; dataB = 0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    mA = modelReset(mA);
    mB = modelReset(mB);
    checkOutput("reset.outA", 64'(outA), 64'h01);
    checkOutput("reset.outB", 64'(outB), 64'h01);
    checkOutput("reset.periodA", 64'(periodA), 64'h0);
    checkOutput("reset.pvA", 64'(pvA), 64'h0);
    checkOutput("reset.pvB", 64'(pvB), 64'h0);

    foreach (vecA[i]) begin
      applyStimulus(vecA[i].s, idle);
      checkOutput($sformatf("vec%0d.out", i), 64'(outA), 64'(vecA[i].expOut));
    end

    // Corrupt taps and start a seed load, then reset asynchronously mid-cycle.
    applyStimulus(mk(0, 1, 2'b10, 4'hF), idle);
    applyStimulus(mk(0, 1, 2'b01, 4'h5), idle);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("asyncReset.outA", 64'(outA), 64'h01);
    checkOutput("asyncReset.outB", 64'(outB), 64'h01);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    mA = modelReset(mA);
    mB = modelReset(mB);
    applyStimulus(mk(0, 1, 2'b11, 4'h0), idle);
    checkOutput("resetTaps.out", 64'(outA), 64'h00);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(idle, mk(1, 0, 2'b00, 4'h0));
      checkOutput($sformatf("seqB%0d.out", i), 64'(outB), 64'(seqB[i]));
      if (i == 13) checkOutput("seqB.pvEarly", 64'(pvB), 64'h0);
    end
    checkOutput("seqB.period", 64'(periodB), PERIOD_EN ? 64'd15 : 64'd0);
    checkOutput("seqB.pv", 64'(pvB), PERIOD_EN ? 64'd1 : 64'd0);
    repeat (5) applyStimulus(idle, mk(1, 0, 2'b00, 4'h0));
    applyStimulus(idle, mk(1, 1, 2'b10, 4'hC));
    checkOutput("tapsMid.pv", 64'(pvB), 64'h0);
    for (int i = 0; i < 15; i++) applyStimulus(idle, mk(1, 0, 2'b00, 4'h0));
    checkOutput("tapsMid.period", 64'(periodB), PERIOD_EN ? 64'd15 : 64'd0);
    applyStimulus(idle, idle);

    applyStimulus(mk(0, 1, 2'b01, 4'h0), idle);
    applyStimulus(mk(0, 1, 2'b01, 4'h0), idle);
    applyStimulus(mk(0, 1, 2'b01, 4'h1), idle);
    applyStimulus(mk(0, 1, 2'b01, 4'h2), idle);
    for (int k = 0; k < 16; k++) begin
      if (k == 11) applyStimulus(mk(1, 1, 2'b11, 4'h0), idle);
      else applyStimulus(mk(1, 0, 2'b00, 4'h0), idle);
      checkOutput($sformatf("presc%0d.out", k), 64'(outA), 64'(expPre[k]));
    end
    applyStimulus(idle, idle);

    ra = idle;
    rb = idle;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(9) == 0) ra.run = ~ra.run;
      if ($urandom_range(9) == 0) rb.run = ~rb.run;
      ra.cv = ($urandom_range(3) == 0);
      rb.cv = ($urandom_range(5) == 0);
      ra.cmd = 2'($urandom_range(3, 1));
      rb.cmd = 2'($urandom_range(3, 1));
      ra.data = 4'($urandom);
      rb.data = 4'($urandom);
      applyStimulus(ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
